// File: rtl/meta_pkg.sv
// Shared constants for the metadata streamer: protocol tokens, identity strings,
// image layout offsets and the streaming FSM state type.
package meta_pkg;

    localparam logic [7:0] TOK_END    = 8'h00;
    localparam logic [7:0] TOK_NAME   = 8'h01;
    localparam logic [7:0] TOK_FW     = 8'h02;
    localparam logic [7:0] TOK_MEM    = 8'h21;
    localparam logic [7:0] TOK_RATE   = 8'h23;
    localparam logic [7:0] TOK_PROBES = 8'h40;
    localparam logic [7:0] TOK_PROTO  = 8'h41;

    localparam int                    NAME_LEN    = 7;
    localparam logic [8*NAME_LEN-1:0] DEVICE_NAME = "META-LA";
    localparam int                    FW_LEN      = 4;
    localparam logic [8*FW_LEN-1:0]   FW_VERSION  = "1.02";

    // Byte offset of each token within the image; every field is token + payload.
    localparam int OFS_NAME   = 0;
    localparam int OFS_FW     = OFS_NAME + NAME_LEN + 2;
    localparam int OFS_MEM    = OFS_FW + FW_LEN + 2;
    localparam int OFS_RATE   = OFS_MEM + 5;
    localparam int OFS_PROBES = OFS_RATE + 5;
    localparam int OFS_PROTO  = OFS_PROBES + 2;
    localparam int OFS_END    = OFS_PROTO + 2;
    localparam int META_LEN   = OFS_END + 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_IDLE
    } meta_state_e;

    // Character i (leftmost first) of a packed string literal of length len.
    function automatic logic [7:0] str_char(input logic [63:0] s, input int len, input int i);
        return s[8*(len-1-i) +: 8];
    endfunction

endpackage

// File: rtl/meta_rom.sv
// Metadata image builder with a registered read port; the read data is zero
// whenever no read is requested so it can drive the byte bus directly.
module meta_rom
    import meta_pkg::*;
#(
    parameter int          DEPTH       = 64,
    parameter logic [31:0] MAX_RATE_HZ = 32'h0BEB_C200,
    parameter logic [7:0]  PROTO_VER   = 8'h02
) (
    input  logic                     clock,
    input  logic                     extReset,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    input  logic [31:0]              mem_bytes,
    input  logic [7:0]               num_probes,
    output logic [7:0]               rd_data
);

    if (META_LEN > DEPTH) begin : g_len_check
        $error("meta_rom: image length %0d exceeds DEPTH %0d", META_LEN, DEPTH);
    end

    logic [7:0] image [DEPTH];

    // NOTE: every entry gets a default before the field writes, so no latch is inferred.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) image[i] = TOK_END;
        image[OFS_NAME] = TOK_NAME;
        for (int i = 0; i < NAME_LEN; i++)
            image[OFS_NAME+1+i] = str_char(64'(DEVICE_NAME), NAME_LEN, i);
        image[OFS_FW] = TOK_FW;
        for (int i = 0; i < FW_LEN; i++)
            image[OFS_FW+1+i] = str_char(64'(FW_VERSION), FW_LEN, i);
        image[OFS_MEM]  = TOK_MEM;
        image[OFS_RATE] = TOK_RATE;
        for (int i = 0; i < 4; i++) begin
            image[OFS_MEM+1+i]  = mem_bytes[8*(3-i) +: 8];
            image[OFS_RATE+1+i] = MAX_RATE_HZ[8*(3-i) +: 8];
        end
        image[OFS_PROBES]   = TOK_PROBES;
        image[OFS_PROBES+1] = num_probes;
        image[OFS_PROTO]    = TOK_PROTO;
        image[OFS_PROTO+1]  = PROTO_VER;
    end

    // NOTE: the image is pure logic, so only the output register needs a reset.
    always_ff @(posedge clock) begin
        if (extReset)   rd_data <= 8'h00;
        else if (rd_en) rd_data <= image[rd_addr];
        else            rd_data <= 8'h00;
    end

endmodule

// File: rtl/meta_streamer.sv
// Streams the metadata image one byte per transmitter handshake on a query edge.
// Optional META_PATCH_EN: memory size and probe count come from patch inputs.
module meta_streamer
    import meta_pkg::*;
#(
    parameter int          DEPTH        = 64,
    parameter logic [31:0] MEM_BYTES    = 32'h0000_4000,
    parameter logic [31:0] MAX_RATE_HZ  = 32'h0BEB_C200,
    parameter logic [7:0]  NUM_PROBES   = 8'h20,
    parameter logic [7:0]  PROTO_VER    = 8'h02,
    parameter int          BUSY_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        extReset,
    input  logic        query_metadata,
    input  logic        xmit_idle,
    input  logic        abort,
    input  logic [7:0]  patch_probes,
    input  logic [31:0] patch_mem,
    output logic        writeMeta,
    output logic [7:0]  meta_data,
    output logic        busy,
    output logic        done
);

    localparam int                IDX_W    = $clog2(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(META_LEN - 1);
    localparam logic [8:0]        TIMEOUT  = 9'(BUSY_TIMEOUT);

    if (DEPTH < 32 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("meta_streamer: DEPTH %0d must be a power of two in 32..256", DEPTH);
    end
    if (BUSY_TIMEOUT < 1 || BUSY_TIMEOUT > 255) begin : g_timeout_check
        $error("meta_streamer: BUSY_TIMEOUT %0d outside 1..255", BUSY_TIMEOUT);
    end

    meta_state_e      state, state_n;
    logic [IDX_W-1:0] index, index_n;
    logic [7:0]       tcnt, tcnt_n;
    logic             pending, pending_n;
    logic             query_q;
    logic             done_n;
    logic             capture;
    logic             query_rise;
    logic [31:0]      mem_val;
    logic [7:0]       probes_val;

    assign query_rise = query_metadata & ~query_q;
    assign busy       = (state != IDLE);

    always_comb begin
        state_n   = state;
        index_n   = index;
        tcnt_n    = tcnt;
        pending_n = pending;
        done_n    = 1'b0;
        capture   = 1'b0;
        unique case (state)
            IDLE: begin
                if (query_rise || pending) begin
                    if (xmit_idle) begin
                        state_n   = SEND;
                        index_n   = '0;
                        pending_n = 1'b0;
                        capture   = 1'b1;
                    end else begin
                        pending_n = 1'b1;
                    end
                end
            end
            SEND: begin
                tcnt_n  = '0;
                state_n = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // Leave once the transmitter reports busy, or after BUSY_TIMEOUT cycles here.
                if (!xmit_idle || ({1'b0, tcnt} + 9'd1 == TIMEOUT)) state_n = WAIT_IDLE;
                else                                                 tcnt_n  = tcnt + 8'd1;
            end
            WAIT_IDLE: begin
                if (xmit_idle) begin
                    if (index == LAST_IDX) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        index_n = index + 1'b1;
                        state_n = SEND;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (abort && state != IDLE) begin
            state_n = IDLE;
            done_n  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (extReset) begin
            state     <= IDLE;
            index     <= '0;
            tcnt      <= '0;
            pending   <= 1'b0;
            query_q   <= 1'b0;
            writeMeta <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            index     <= index_n;
            tcnt      <= tcnt_n;
            pending   <= pending_n;
            query_q   <= query_metadata;
            writeMeta <= (state_n == SEND);
            done      <= done_n;
        end
    end

`ifdef META_PATCH_EN
    logic [31:0] mem_q;
    logic [7:0]  probes_q;

    always_ff @(posedge clock) begin
        if (extReset) begin
            mem_q    <= '0;
            probes_q <= '0;
        end else if (capture) begin
            mem_q    <= patch_mem;
            probes_q <= patch_probes;
        end
    end

    assign mem_val    = mem_q;
    assign probes_val = probes_q;
`else
    logic unused_patch;
    assign unused_patch = ^{patch_probes, patch_mem, capture};
    assign mem_val      = MEM_BYTES;
    assign probes_val   = NUM_PROBES;
`endif

    meta_rom #(
        .DEPTH      (DEPTH),
        .MAX_RATE_HZ(MAX_RATE_HZ),
        .PROTO_VER  (PROTO_VER)
    ) u_rom (
        .clock     (clock),
        .extReset  (extReset),
        .rd_en     (state_n == SEND),
        .rd_addr   (index_n),
        .mem_bytes (mem_val),
        .num_probes(probes_val),
        .rd_data   (meta_data)
    );

endmodule

// File: doc/meta_streamer.md
META_STREAMER -- requirements
Module: meta_streamer

Interface
REQ-001 SHALL have parameter DEPTH, 64, ROM depth in bytes; power of two, 32..256.
REQ-002 SHALL have parameter MEM_BYTES, 32'h0000_4000, sample-memory size reported under token 0x21.
REQ-003 SHALL have parameter MAX_RATE_HZ, 32'h0BEB_C200, max sample rate reported under token 0x23.
REQ-004 SHALL have parameter NUM_PROBES, 8'h20, probe count reported under token 0x40.
REQ-005 SHALL have parameter PROTO_VER, 8'h02, protocol version reported under token 0x41.
REQ-006 SHALL have parameter BUSY_TIMEOUT, 255, max cycles to wait for xmit_idle to drop after a write; range 1..255.
REQ-007 SHALL have ports: clock  in  1  sole clock, rising edge.
REQ-008 extReset  in  1  reset; synchronous, active-high.
REQ-009 query_metadata  in  1  metadata request, level input, acted on at rising edge.
REQ-010 xmit_idle  in  1  transmitter idle/ready.
REQ-011 abort  in  1  cancel current stream.
REQ-012 patch_probes  in  8  runtime probe count (META_PATCH_EN only).
REQ-013 patch_mem  in  32  runtime memory size (META_PATCH_EN only).
REQ-014 writeMeta  out  1  one-cycle byte strobe.
REQ-015 meta_data  out  8  byte, valid while writeMeta=1.
REQ-016 busy  out  1  high in any state but IDLE.
REQ-017 done  out  1  one-cycle pulse after final byte accepted.

Function
REQ-018 ROM image SHALL be, in order: 0x01, device-name string, 0x00; 0x02, firmware-version string, 0x00; 0x21 + MEM_BYTES (4 bytes, MSB first); 0x23 + MAX_RATE_HZ (4 bytes, MSB first); 0x40 + NUM_PROBES; 0x41 + PROTO_VER; 0x00 terminator; unused entries 0x00.
REQ-019 LEN (total image bytes) SHALL be a constant; LEN > DEPTH SHALL fail elaboration.
REQ-020 FSM states SHALL be IDLE, SEND, WAIT_BUSY, WAIT_IDLE.
REQ-021 IDLE->SEND SHALL occur on the cycle after a 0->1 transition of query_metadata sampled with xmit_idle=1; index cleared to 0; held-high query SHALL NOT retrigger.
REQ-022 A rising edge while xmit_idle=0 SHALL be held pending and honoured the first cycle xmit_idle=1 while still in IDLE.
REQ-023 SEND SHALL assert writeMeta for exactly one cycle with meta_data=image[index], then go to WAIT_BUSY.
REQ-024 WAIT_BUSY SHALL go to WAIT_IDLE when xmit_idle=0, or when the timeout counter (cleared in SEND) reaches BUSY_TIMEOUT.
REQ-025 WAIT_IDLE on xmit_idle=1 SHALL: if index=LEN-1, go to IDLE and pulse done; else increment index and go to SEND.
REQ-026 Minimum per-byte period SHALL be 3 cycles (SEND, WAIT_BUSY, WAIT_IDLE).
REQ-027 abort=1 in any non-IDLE state SHALL return to IDLE next cycle; no done, no further writeMeta; abort has priority over all other transitions.
REQ-028 Query edges occurring while busy=1 SHALL be discarded.
REQ-029 meta_data SHALL be registered and SHALL read 0x00 whenever writeMeta=0.

Reset
REQ-030 extReset SHALL, on the next clock edge, force IDLE, index=0, timeout counter=0, pending flag=0, query edge-detect register=0, writeMeta=0, meta_data=0x00, busy=0, done=0.
REQ-031 extReset mid-stream SHALL terminate the stream with no further strobe and no done.

Configuration
REQ-032 With META_PATCH_EN defined, the 0x21 and 0x40 payloads SHALL come from patch_mem and patch_probes captured on the IDLE->SEND transition and held constant for the stream.
REQ-033 Without META_PATCH_EN, payloads SHALL come from MEM_BYTES/NUM_PROBES and patch inputs SHALL be unused.

Structure
REQ-034 Package meta_pkg SHALL hold token constants (0x01, 0x02, 0x21, 0x23, 0x40, 0x41, 0x00), device-name and version strings, and the state enum.
REQ-035 Sub-module meta_rom (image build plus registered read, parameterised DEPTH) SHALL be instantiated once.

Verification
REQ-036 xmit_idle tied to a model dropping 1 cycle after writeMeta and rising 2 cycles later, query pulse -> LEN strobes, byte 0 = 0x01, final = 0x00, one done.
REQ-037 query held high 1000 cycles -> exactly one stream, one done.
REQ-038 abort asserted after 5th strobe -> IDLE next cycle, exactly 5 strobes, done never asserted.
REQ-039 xmit_idle stuck 1, BUSY_TIMEOUT=4 -> strobes spaced 6 cycles apart, stream completes.
REQ-040 META_PATCH_EN, patch_probes=0x10, patch_mem=0x0001_0000, changed to 0x08 mid-stream -> 0x40 payload 0x10, 0x21 payload 00 01 00 00.
REQ-041 extReset during WAIT_IDLE -> all outputs 0 next cycle; next query edge starts at byte 0x01.
